// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
//   Shared definitions for the 7-segment scan controller:
//     state_t      - scan FSM states (S_BLANK, S_DRIVE)
//     SEG_OFF      - active-high "all segments off" pattern
//     GLYPH_TABLE  - 16-entry hex glyph table, active-high {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   typedef enum logic [0:0] {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry h is the glyph for hex digit h (entry 0 is the rightmost element).
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/hex_seg_decoder.sv
// -----------------------------------------------------------------------------
// hex_seg_decoder
//   Purely combinational hex nibble to 7-segment glyph decoder (active-high).
//   Ports:
//     hex  in  4   nibble to decode
//     seg  out 7   seg[0]=a ... seg[6]=g, 1 = segment lit
// -----------------------------------------------------------------------------
module hex_seg_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   import seg_scan_pkg::*;

   assign seg = GLYPH_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an N-digit 7-segment display. One
//   shared decoder is muxed across digits; each digit slot starts with a
//   blanking gap to stop ghosting. A newly loaded value is held pending and
//   committed only at the frame boundary so a frame never mixes two values.
//
//   Ports:
//     clk          in   1             clock, rising edge
//     reset        in   1             synchronous, active-high
//     load         in   1             strobe: capture data_in as pending value
//     data_in      in   4*NUM_DIGITS  nibble k drives digit k
//     upd_pending  out  1             pending value not yet committed
//     frame_tick   out  1             one-cycle pulse after each frame boundary
//     an           out  NUM_DIGITS    one-hot digit enable (ACTIVE_LOW polarity)
//     seg          out  7             segments a..g (ACTIVE_LOW polarity)
//
//   Optional feature macro: SEG_LZ_BLANK_EN
//     defined   - leading-zero digits (k>0 with nibbles k..N-1 all zero) show
//                 no segments; their enable is still scanned.
//     undefined - every digit shows its glyph.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   output logic                      upd_pending,
   output logic                      frame_tick,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg
);
   import seg_scan_pkg::*;

   // One counter serves both states, so size it for the longer of the two.
   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

   localparam logic [NUM_DIGITS-1:0] AN_IDLE =
      (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [6:0] SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [DIG_W-1:0]          dig_reg, dig_next;
   logic [4*NUM_DIGITS-1:0]   pend_reg;
   logic [4*NUM_DIGITS-1:0]   disp_reg;
   logic                      upd_pending_reg;
   logic                      frame_tick_reg;
   logic [NUM_DIGITS-1:0]     an_reg, an_next;
   logic [6:0]                seg_reg, seg_next;

   logic                      boundary;
   logic [3:0]                digit_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     digit_blank;
   logic [NUM_DIGITS-1:0]     dig_onehot;
   logic [3:0]                cur_nib;
   logic [6:0]                cur_glyph;

   // ---------------------------------------------------------------------
   // Scan FSM: BLANK_CYCLES off, then SCAN_DIV driving the current digit.
   // boundary marks the last drive cycle of the last digit.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + 1'b1;
      dig_next   = dig_reg;
      boundary   = 1'b0;
      if (state_reg == S_BLANK) begin
         if (cnt_reg == BLANK_LAST) begin
            state_next = S_DRIVE;
            cnt_next   = '0;
         end
      end else begin
         if (cnt_reg == DRIVE_LAST) begin
            state_next = S_BLANK;
            cnt_next   = '0;
            if (dig_reg == DIG_LAST) begin
               dig_next = '0;
               boundary = 1'b1;
            end else begin
               dig_next = dig_reg + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Per-digit views of the displayed value, enable decode and blanking.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_nib[gi]  = disp_reg[4*gi +: 4];
      assign dig_onehot[gi] = (dig_reg == DIG_W'(gi));
   end

`ifdef SEG_LZ_BLANK_EN
   // A digit is a leading zero when it and every more-significant nibble are
   // zero; digit 0 always shows so a zero value still displays "0".
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
         assign digit_blank[gi] = 1'b0;
      end else begin : g_upper
         assign digit_blank[gi] = (disp_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
   end
`else
   assign digit_blank = '0;
`endif

   assign cur_nib = digit_nib[dig_reg];

   hex_seg_decoder u_dec (
      .hex (cur_nib),
      .seg (cur_glyph)
   );

   // Output pattern for the next cycle, polarity applied before registering.
   always_comb begin
      an_next  = '0;
      seg_next = SEG_OFF;
      if (state_reg == S_DRIVE) begin
         an_next = dig_onehot;
         if (!digit_blank[dig_reg]) begin
            seg_next = cur_glyph;
         end
      end
      if (ACTIVE_LOW != 0) begin
         an_next  = ~an_next;
         seg_next = ~seg_next;
      end
   end

   // ---------------------------------------------------------------------
   // State, value and output registers.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_BLANK;
         cnt_reg         <= '0;
         dig_reg         <= '0;
         pend_reg        <= '0;
         disp_reg        <= '0;
         upd_pending_reg <= 1'b0;
         frame_tick_reg  <= 1'b0;
         an_reg          <= AN_IDLE;
         seg_reg         <= SEG_IDLE;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         dig_reg        <= dig_next;
         frame_tick_reg <= boundary;
         an_reg         <= an_next;
         seg_reg        <= seg_next;

         if (load) begin
            pend_reg <= data_in;
         end

         // A load on the boundary cycle bypasses pend_reg so it is not
         // delayed by a whole frame.
         if (boundary && (upd_pending_reg || load)) begin
            disp_reg        <= load ? data_in : pend_reg;
            upd_pending_reg <= 1'b0;
         end else if (load) begin
            upd_pending_reg <= 1'b1;
         end
      end
   end

   assign upd_pending = upd_pending_reg;
   assign frame_tick  = frame_tick_reg;
   assign an          = an_reg;
   assign seg         = seg_reg;

endmodule
